// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode types, opcode constants and instruction tables
// Contents: form encodings, op constants, LONG/LEGAL opcode tables, default boot address.
package cpu_pkg;

    localparam logic [31:0] DEF_BOOT_ADDR = 32'h0000_1000;

    typedef enum logic [1:0] {
        FORM1 = 2'd0,
        FORM2 = 2'd1,
        FORM3 = 2'd2
    } form_e;

    localparam logic [7:0] OP_LDI_L = 8'h01;
    localparam logic [7:0] OP_JSRA  = 8'h03;
    localparam logic [7:0] OP_NOP   = 8'h0f;
    localparam logic [7:0] OP_JMPA  = 8'h1a;

    // Form-1 ops followed by a 32-bit operand word (6-byte instructions)
    function automatic logic is_long_op(input logic [7:0] op);
        return op inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d,
                          8'h1f, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39};
    endfunction

    // Implemented moxie opcodes: form 1 ops 0x01-0x15 and 0x19-0x39,
    // every form 2 op, form 3 branch conditions 0-9
    function automatic logic is_legal(input logic [15:0] opc);
        return !opc[15] ? (opc[15:8] inside {[8'h01:8'h15], [8'h19:8'h39]})
                        : (!opc[14] || opc[13:10] <= 4'd9);
    endfunction

endpackage

// File: rtl/cpu_decode_if.sv
// cpu_decode_if: fetch-FIFO and execute-side handshake bundle of the decode stage
// Fetch side : opcode_i, operand_i, valid_i -> decode; read_en_o, long_o <- decode
// Execute side: ready_i -> decode; dvalid_o, pc_o, form_o, op_o, ra_o, rb_o, imm_o, illegal_o <- decode
// slave = decode stage view, master = surrounding fetch/execute view.
interface cpu_decode_if #(
    parameter int unsigned PC_W = 32
);
    logic [15:0]     opcode_i;
    logic [31:0]     operand_i;
    logic            valid_i;
    logic            read_en_o;
    logic            long_o;
    logic            ready_i;
    logic            dvalid_o;
    logic [PC_W-1:0] pc_o;
    logic [1:0]      form_o;
    logic [7:0]      op_o;
    logic [3:0]      ra_o;
    logic [3:0]      rb_o;
    logic [PC_W-1:0] imm_o;
    logic            illegal_o;

    modport slave (
        input  opcode_i, operand_i, valid_i, ready_i,
        output read_en_o, long_o, dvalid_o, pc_o, form_o, op_o, ra_o, rb_o, imm_o, illegal_o
    );

    modport master (
        output opcode_i, operand_i, valid_i, ready_i,
        input  read_en_o, long_o, dvalid_o, pc_o, form_o, op_o, ra_o, rb_o, imm_o, illegal_o
    );
endinterface

// File: rtl/cpu_decode_classify.sv
// cpu_decode_classify: combinational opcode classifier (form, op, register fields, length, legality)
// Ports: opcode_i in 16; form_o, op_o, ra_o, rb_o, long_o, illegal_o out.
// Option CPU_DECODE_ILLEGAL_TRAP_EN: report illegal opcodes instead of turning them into nop.
module cpu_decode_classify
    import cpu_pkg::*;
(
    input  logic [15:0] opcode_i,
    output form_e       form_o,
    output logic [7:0]  op_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic        long_o,
    output logic        illegal_o
);
    form_e      form_raw;
    logic [7:0] op_raw;
    logic [3:0] ra_raw;
    logic [3:0] rb_raw;
    logic       long_raw;
    logic       bad;

    always_comb begin
        form_raw = !opcode_i[15] ? FORM1 : (opcode_i[14] ? FORM3 : FORM2);
        op_raw   = form_raw == FORM1 ? opcode_i[15:8]
                 : form_raw == FORM2 ? {6'b0, opcode_i[13:12]} : {4'b0, opcode_i[13:10]};
        ra_raw   = form_raw == FORM1 ? opcode_i[7:4] : form_raw == FORM2 ? opcode_i[11:8] : 4'd0;
        rb_raw   = form_raw == FORM1 ? opcode_i[3:0] : 4'd0;
        long_raw = form_raw == FORM1 && is_long_op(opcode_i[15:8]);
        bad      = !is_legal(opcode_i);
    end

`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
    assign form_o    = form_raw;
    assign op_o      = op_raw;
    assign ra_o      = ra_raw;
    assign rb_o      = rb_raw;
    assign long_o    = long_raw;
    assign illegal_o = bad;
`else
    // Unimplemented opcodes become a short form-1 nop so the pipeline keeps flowing
    assign form_o    = bad ? FORM1 : form_raw;
    assign op_o      = bad ? OP_NOP : op_raw;
    assign ra_o      = bad ? 4'd0 : ra_raw;
    assign rb_o      = bad ? 4'd0 : rb_raw;
    assign long_o    = !bad && long_raw;
    assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: moxie decode stage between the fetch FIFO and execute
// Ports: clk_i, rst_i (sync, active-high); flush_i, flush_pc_i redirect from execute;
//        bus (cpu_decode_if.slave) carries the FIFO read handshake and the registered decode packet.
// Option CPU_DECODE_ILLEGAL_TRAP_EN: an illegal packet blocks further accepts until the next flush.
module cpu_decode
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] BOOT_ADDR = PC_W'(DEF_BOOT_ADDR)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] flush_pc_i,
    cpu_decode_if.slave     bus
);
    form_e           form;
    logic [7:0]      op;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic            is_long;
    logic            illegal;
    logic            accept;
    logic            trap_hold;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] imm_d;
    logic [PC_W-1:0] pc_q;
    logic            dvalid_q;
    logic [PC_W-1:0] pkt_pc_q;
    form_e           form_q;
    logic [7:0]      op_q;
    logic [3:0]      ra_q;
    logic [3:0]      rb_q;
    logic [PC_W-1:0] imm_q;
    logic            illegal_q;

    cpu_decode_classify u_classify (
        .opcode_i  (bus.opcode_i),
        .form_o    (form),
        .op_o      (op),
        .ra_o      (ra),
        .rb_o      (rb),
        .long_o    (is_long),
        .illegal_o (illegal)
    );

    // A new packet may load when the slot is empty or is retiring this cycle
    assign accept = bus.valid_i && (!dvalid_q || bus.ready_i) && !flush_i && !rst_i && !trap_hold;

    // Branch displacement in halfwords, relative to the following instruction
    assign br_off = {{(PC_W-11){bus.opcode_i[9]}}, bus.opcode_i[9:0], 1'b0};
    assign imm_d  = form == FORM3 ? pc_q + PC_W'(2) + br_off
                  : form == FORM2 ? PC_W'(bus.opcode_i[7:0])
                  : is_long       ? PC_W'(bus.operand_i) : '0;

`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i)
            trap_q <= 1'b0;
        else if (accept && illegal)
            trap_q <= 1'b1;
    end
    assign trap_hold = trap_q;
`else
    assign trap_hold = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dvalid_q  <= 1'b0;
            pc_q      <= BOOT_ADDR;
            pkt_pc_q  <= '0;
            form_q    <= FORM1;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else if (flush_i) begin
            dvalid_q  <= 1'b0;
            pc_q      <= flush_pc_i;
        end else if (accept) begin
            dvalid_q  <= 1'b1;
            pc_q      <= pc_q + (is_long ? PC_W'(6) : PC_W'(2));
            pkt_pc_q  <= pc_q;
            form_q    <= form;
            op_q      <= op;
            ra_q      <= ra;
            rb_q      <= rb;
            imm_q     <= imm_d;
            illegal_q <= illegal;
        end else if (bus.ready_i) begin
            dvalid_q  <= 1'b0;
        end
    end

    assign bus.read_en_o = accept;
    assign bus.long_o    = accept && is_long;
    assign bus.dvalid_o  = dvalid_q;
    assign bus.pc_o      = pkt_pc_q;
    assign bus.form_o    = form_q;
    assign bus.op_o      = op_q;
    assign bus.ra_o      = ra_q;
    assign bus.rb_o      = rb_q;
    assign bus.imm_o     = imm_q;
    assign bus.illegal_o = illegal_q;

endmodule

// File: tb/tb_cpu_decode.sv
// tb_cpu_decode: self-checking bench for cpu_decode (vector table, hand sequences, random vs model)
module tb_cpu_decode;

`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] BOOT = 32'h0000_1000;
    localparam logic [7:0] LONG_LIST [18] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d,
                                              8'h1f, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39};

    typedef struct packed {
        logic [1:0]  form;
        logic [7:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] imm;
        logic        lng;
        logic        ill;
    } pkt_t;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] opc;
        logic [31:0] opd;
        pkt_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    int          checks = 0;
    int          errors = 0;

    logic        m_dv;
    logic        m_trap;
    logic [31:0] m_pc;
    logic [31:0] m_ppc;
    pkt_t        m_pkt;
    logic        seen_long;
    vec_t        vecs [13];

    cpu_decode_if #(.PC_W(32)) bus ();

    cpu_decode #(.PC_W(32), .BOOT_ADDR(BOOT)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .flush_pc_i (flush_pc),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [1:0] f, input logic [7:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [31:0] imm, input logic lng, input logic ill);
        pkt_t p;
        p.form = f; p.op = op; p.ra = ra; p.rb = rb; p.imm = imm; p.lng = lng; p.ill = ill;
        return p;
    endfunction

    function automatic vec_t vec(input logic [31:0] pc, input logic [15:0] opc, input logic [31:0] opd, input pkt_t e);
        vec_t v;
        v.pc = pc; v.opc = opc; v.opd = opd; v.exp = e;
        return v;
    endfunction

    // Reference decode straight from the instruction-set rules
    function automatic pkt_t ref_dec(input logic [15:0] o, input logic [31:0] opd, input logic [31:0] pc);
        pkt_t p;
        int   off;
        int   op1;
        logic legal;
        p = '0;
        if (!o[15]) begin
            op1 = int'(o[15:8]);
            p.op = o[15:8]; p.ra = o[7:4]; p.rb = o[3:0];
            for (int i = 0; i < 18; i++) if (LONG_LIST[i] == o[15:8]) p.lng = 1'b1;
            p.imm = p.lng ? opd : 32'd0;
            legal = op1 >= 1 && op1 <= 'h39 && !(op1 >= 'h16 && op1 <= 'h18);
        end else if (!o[14]) begin
            p.form = 2'd1; p.op = {6'b0, o[13:12]}; p.ra = o[11:8]; p.imm = {24'b0, o[7:0]};
            legal = 1'b1;
        end else begin
            off = $signed(o[9:0]);
            p.form = 2'd2; p.op = {4'b0, o[13:10]}; p.imm = pc + 32'(2 + 2 * off);
            legal = int'(o[13:10]) < 10;
        end
        if (!legal) begin
            if (TRAP) p.ill = 1'b1;
            else begin p = '0; p.op = 8'h0f; end
        end
        return p;
    endfunction

    // One clock: drive at negedge, check combinational outputs, advance model, check packet
    task automatic step(input logic r, input logic v, input logic [15:0] opc, input logic [31:0] opd,
                        input logic rdy, input logic fl, input logic [31:0] fpc);
        logic acc;
        pkt_t np;
        rst = r; bus.valid_i = v; bus.opcode_i = opc; bus.operand_i = opd; bus.ready_i = rdy;
        flush = fl; flush_pc = fpc;
        #1;
        np  = ref_dec(opc, opd, m_pc);
        acc = v && (!m_dv || rdy) && !fl && !r && !m_trap;
        chk("read_en", bus.read_en_o, acc);
        chk("long", bus.long_o, acc && np.lng);
        seen_long = bus.long_o;
        @(posedge clk);
        if (r) begin
            m_dv = 1'b0; m_pc = BOOT; m_ppc = '0; m_pkt = '0; m_trap = 1'b0;
        end else if (fl) begin
            m_dv = 1'b0; m_pc = fpc; m_trap = 1'b0;
        end else if (acc) begin
            m_dv = 1'b1; m_pkt = np; m_ppc = m_pc; m_pc = m_pc + (np.lng ? 32'd6 : 32'd2); m_trap = np.ill;
        end else if (rdy) begin
            m_dv = 1'b0;
        end
        @(negedge clk);
        chk("dvalid", bus.dvalid_o, m_dv);
        chk("pc", bus.pc_o, m_ppc);
        chk("form", bus.form_o, m_pkt.form);
        chk("op", bus.op_o, m_pkt.op);
        chk("ra", bus.ra_o, m_pkt.ra);
        chk("rb", bus.rb_o, m_pkt.rb);
        chk("imm", bus.imm_o, m_pkt.imm);
        chk("illegal", bus.illegal_o, m_pkt.ill);
    endtask

    initial begin
        vecs[0]  = vec(32'h1000, 16'h0f00, 32'h0, mk(2'd0, 8'h0f, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
        vecs[1]  = vec(32'h1002, 16'h0110, 32'hdeadbeef, mk(2'd0, 8'h01, 4'h1, 4'h0, 32'hdeadbeef, 1'b1, 1'b0));
        vecs[2]  = vec(32'h3000, 16'h8305, 32'h0, mk(2'd1, 8'h00, 4'h3, 4'h0, 32'h5, 1'b0, 1'b0));
        vecs[3]  = vec(32'h2000, 16'hc3ff, 32'h0, mk(2'd2, 8'h00, 4'h0, 4'h0, 32'h2000, 1'b0, 1'b0));
        vecs[4]  = vec(32'h2000, 16'hc401, 32'h0, mk(2'd2, 8'h01, 4'h0, 4'h0, 32'h2004, 1'b0, 1'b0));
        vecs[5]  = vec(32'h0100, 16'he200, 32'h0, mk(2'd2, 8'h08, 4'h0, 4'h0, 32'hfffffd02, 1'b0, 1'b0));
        vecs[6]  = vec(32'hfffffffe, 16'hc1ff, 32'h0, mk(2'd2, 8'h00, 4'h0, 4'h0, 32'h3fe, 1'b0, 1'b0));
        vecs[7]  = vec(32'h1000, 16'h0523, 32'h0, mk(2'd0, 8'h05, 4'h2, 4'h3, 32'h0, 1'b0, 1'b0));
        vecs[8]  = vec(32'h1000, 16'h9a7f, 32'h0, mk(2'd1, 8'h01, 4'ha, 4'h0, 32'h7f, 1'b0, 1'b0));
        vecs[9]  = vec(32'h1000, 16'h0c45, 32'h12345678, mk(2'd0, 8'h0c, 4'h4, 4'h5, 32'h12345678, 1'b1, 1'b0));
        vecs[10] = vec(32'h1000, 16'h0245, 32'hffffffff, mk(2'd0, 8'h02, 4'h4, 4'h5, 32'h0, 1'b0, 1'b0));
`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
        vecs[11] = vec(32'h1000, 16'h3f00, 32'h0, mk(2'd0, 8'h3f, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1));
        vecs[12] = vec(32'h1000, 16'hf000, 32'h0, mk(2'd2, 8'h0c, 4'h0, 4'h0, 32'h1002, 1'b0, 1'b1));
`else
        vecs[11] = vec(32'h1000, 16'h3f00, 32'h0, mk(2'd0, 8'h0f, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
        vecs[12] = vec(32'h1000, 16'hf000, 32'h0, mk(2'd0, 8'h0f, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0));
`endif
        m_dv = 1'b0; m_trap = 1'b0; m_pc = BOOT; m_ppc = '0; m_pkt = '0;

        // Reset held with the FIFO already non-empty, then release
        step(1, 1, 16'h0f00, 0, 1, 0, 0);
        step(1, 1, 16'h0f00, 0, 1, 0, 0);
        step(0, 1, 16'h0f00, 0, 1, 0, 0);
        chk("boot_dvalid", bus.dvalid_o, 1);
        chk("boot_pc", bus.pc_o, 32'h1000);
        chk("boot_op", bus.op_o, 32'h0f);
        step(0, 1, 16'h0523, 0, 1, 0, 0);
        chk("second_pc", bus.pc_o, 32'h1002);

        // Execute stalls three cycles with the FIFO full
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 16'h0110, 32'hdeadbeef, 0, 0, 0);
            chk("stall_read_en", bus.read_en_o, 0);
            chk("stall_pc", bus.pc_o, 32'h1002);
            chk("stall_op", bus.op_o, 32'h05);
        end
        step(0, 1, 16'h0110, 32'hdeadbeef, 1, 0, 0);
        chk("long_seen", seen_long, 1);
        chk("long_pc", bus.pc_o, 32'h1004);
        chk("long_imm", bus.imm_o, 32'hdeadbeef);
        step(0, 1, 16'h8305, 0, 1, 0, 0);
        chk("b2b_dvalid", bus.dvalid_o, 1);
        chk("after_long_pc", bus.pc_o, 32'h100a);

        // Flush while the packet is stalled
        step(0, 1, 16'h0f00, 0, 0, 0, 0);
        step(0, 1, 16'h0f00, 0, 0, 1, 32'h4000);
        chk("flush_dvalid", bus.dvalid_o, 0);
        step(0, 1, 16'h0523, 0, 1, 0, 0);
        chk("flush_pc", bus.pc_o, 32'h4000);

        // Reset while a packet is stalled
        step(0, 1, 16'h0f00, 0, 0, 0, 0);
        step(1, 1, 16'h0f00, 0, 0, 0, 0);
        chk("rst_dvalid", bus.dvalid_o, 0);
        chk("rst_pc_o", bus.pc_o, 0);
        step(0, 1, 16'h0f00, 0, 1, 0, 0);
        chk("rst_restart_pc", bus.pc_o, 32'h1000);

        foreach (vecs[i]) begin
            step(0, 0, 16'h0, 0, 1, 1, vecs[i].pc);
            step(0, 1, vecs[i].opc, vecs[i].opd, 1, 0, 0);
            chk($sformatf("tbl%0d_dvalid", i), bus.dvalid_o, 1);
            chk($sformatf("tbl%0d_long", i), seen_long, vecs[i].exp.lng);
            chk($sformatf("tbl%0d_pc", i), bus.pc_o, vecs[i].pc);
            chk($sformatf("tbl%0d_form", i), bus.form_o, vecs[i].exp.form);
            chk($sformatf("tbl%0d_op", i), bus.op_o, vecs[i].exp.op);
            chk($sformatf("tbl%0d_ra", i), bus.ra_o, vecs[i].exp.ra);
            chk($sformatf("tbl%0d_rb", i), bus.rb_o, vecs[i].exp.rb);
            chk($sformatf("tbl%0d_imm", i), bus.imm_o, vecs[i].exp.imm);
            chk($sformatf("tbl%0d_ill", i), bus.illegal_o, vecs[i].exp.ill);
        end

        // Illegal opcode followed by a ready FIFO
        step(0, 0, 16'h0, 0, 1, 1, 32'h1000);
        step(0, 1, 16'h3f00, 0, 1, 0, 0);
        step(0, 1, 16'h0f00, 0, 1, 0, 0);
`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
        chk("trap_dvalid", bus.dvalid_o, 0);
        chk("trap_read_en", bus.read_en_o, 0);
        step(0, 1, 16'h0f00, 0, 1, 1, 32'h5000);
        step(0, 1, 16'h0f00, 0, 1, 0, 0);
        chk("trap_resume_pc", bus.pc_o, 32'h5000);
`else
        chk("nop_dvalid", bus.dvalid_o, 1);
        chk("nop_pc", bus.pc_o, 32'h1002);
`endif

        for (int n = 0; n < 600; n++) begin
            logic [15:0] opc;
            opc = 16'($urandom());
            if ($urandom_range(0, 2) == 0) opc[15:8] = LONG_LIST[$urandom_range(0, 17)];
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, opc, $urandom(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom() & ~32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
